// File: rtl/load_wb_ctrl_pkg.sv
// Shared definitions for the load write-back controller: load types, FSM
// encoding, write-back mux selects and wait-latency bounds.
package load_wb_ctrl_pkg;

  typedef enum logic [1:0] {
    LD_LW  = 2'd0,
    LD_LH  = 2'd1,
    LD_LB  = 2'd2,
    LD_LBU = 2'd3
  } ld_type_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_LATCH = 3'd2,
    S_WB    = 3'd3,
    S_ERR   = 3'd4
  } ld_state_e;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_MDR  = 3'd5;
  localparam logic [2:0] SEL_BH   = 3'd7;

  localparam int MEM_WAIT_MIN = 1;
  localparam int MEM_WAIT_MAX = 15;
  localparam int CNT_W        = $clog2(MEM_WAIT_MAX + 1);

  // Word loads need a 4-byte aligned address, halfword loads a 2-byte one.
  function automatic logic misaligned(input ld_type_e t, input logic [1:0] a);
    return ((t == LD_LW) && (a != 2'd0)) || ((t == LD_LH) && a[0]);
  endfunction

endpackage

// File: rtl/ld_wait_cnt.sv
// Down-counter that paces the memory read; parks at zero.
module ld_wait_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = value;
    else if (dec && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/load_wb_ctrl.sv
// Load write-back sequencer: read wait, MDR latch, register write-back,
// with alignment trapping and flush abort.
module load_wb_ctrl
  import load_wb_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] ld_type,
  input  logic [1:0] addr_lo,
  input  logic       flush,
  output logic       mem_rd,
  output logic       mdr_load,
  output logic [2:0] mem_to_reg,
  output logic       reg_write,
  output logic [1:0] bh_sel,
  output logic       bh_signed,
  output logic       bh_half,
  output logic       busy,
  output logic       done,
  output logic       align_err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_WAIT - 1);

  ld_state_e  state_q;
  ld_type_e   ldt_q;
  ld_type_e   ldt_in;
  logic [1:0] bh_sel_q;
  logic       bh_signed_q, bh_half_q;
  logic       take, bad, cnt_zero;

  assign ldt_in = ld_type_e'(ld_type);
  assign bad    = misaligned(ldt_in, addr_lo);
  // flush outranks a start arriving in IDLE
  assign take   = (state_q == S_IDLE) && start && !flush;

  ld_wait_cnt #(.W(CNT_W)) u_wait (
    .clk  (clk),
    .rst  (reset),
    .load (take && !bad),
    .dec  (state_q == S_WAIT),
    .value(WAIT_INIT),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= S_IDLE;
      ldt_q       <= LD_LW;
      bh_sel_q    <= 2'd0;
      bh_signed_q <= 1'b0;
      bh_half_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:
          if (take) begin
            if (bad) state_q <= S_ERR;
            else begin
              state_q     <= S_WAIT;
              ldt_q       <= ldt_in;
              bh_sel_q    <= addr_lo;
              bh_signed_q <= (ldt_in == LD_LH) || (ldt_in == LD_LB);
              bh_half_q   <= (ldt_in == LD_LH);
            end
          end
        S_WAIT:  if (flush) state_q <= S_IDLE;
                 else if (cnt_zero) state_q <= S_LATCH;
        S_LATCH: state_q <= flush ? S_IDLE : S_WB;
        default: state_q <= S_IDLE;
      endcase
    end

  assign mem_rd     = (state_q == S_WAIT);
  assign mdr_load   = (state_q == S_LATCH);
  assign done       = (state_q == S_WB);
  assign reg_write  = (state_q == S_WB) && !flush;
  assign align_err  = (state_q == S_ERR);
  assign busy       = (state_q != S_IDLE);
  assign mem_to_reg = (state_q != S_WB) ? SEL_NONE :
                      (ldt_q == LD_LW)  ? SEL_MDR  : SEL_BH;
  assign bh_sel     = bh_sel_q;
  assign bh_signed  = bh_signed_q;
  assign bh_half    = bh_half_q;

endmodule

// File: tb/tb_load_wb_ctrl.sv
// Directed bench for load_wb_ctrl at MEM_WAIT = 2 (default), 1 and 15.
module tb_load_wb_ctrl;

  logic clk = 1'b0;
  logic reset, start, start1, start15, flush;
  logic [1:0] ld_type, addr_lo;
  int checks = 0, errors = 0;

  logic mem_rd, mdr_load, reg_write, busy, done, align_err, bh_signed, bh_half;
  logic [2:0] mem_to_reg;
  logic [1:0] bh_sel;
  logic mr1, ml1, rw1, bz1, dn1, ae1, bs1, bhh1;
  logic [2:0] sel1;
  logic [1:0] bsel1;
  logic mr15, ml15, rw15, bz15, dn15, ae15, bs15, bhh15;
  logic [2:0] sel15;
  logic [1:0] bsel15;

  always #5 clk = ~clk;

  load_wb_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ld_type(ld_type), .addr_lo(addr_lo),
    .flush(flush), .mem_rd(mem_rd), .mdr_load(mdr_load), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .bh_sel(bh_sel), .bh_signed(bh_signed), .bh_half(bh_half),
    .busy(busy), .done(done), .align_err(align_err));

  load_wb_ctrl #(.MEM_WAIT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ld_type(ld_type), .addr_lo(addr_lo),
    .flush(1'b0), .mem_rd(mr1), .mdr_load(ml1), .mem_to_reg(sel1),
    .reg_write(rw1), .bh_sel(bsel1), .bh_signed(bs1), .bh_half(bhh1),
    .busy(bz1), .done(dn1), .align_err(ae1));

  load_wb_ctrl #(.MEM_WAIT(15)) dut15 (
    .clk(clk), .reset(reset), .start(start15), .ld_type(ld_type), .addr_lo(addr_lo),
    .flush(1'b0), .mem_rd(mr15), .mdr_load(ml15), .mem_to_reg(sel15),
    .reg_write(rw15), .bh_sel(bsel15), .bh_signed(bs15), .bh_half(bhh15),
    .busy(bz15), .done(dn15), .align_err(ae15));

  logic [8:0] ov;
  logic [3:0] bv;
  assign ov = {mem_rd, mdr_load, reg_write, done, align_err, busy, mem_to_reg};
  assign bv = {bh_sel, bh_signed, bh_half};

  function automatic logic [8:0] ev(input logic mr, ml, rw, dn, ae, bz,
                                    input logic [2:0] sel);
    return {mr, ml, rw, dn, ae, bz, sel};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Accept a load on the next edge, then advance to the WB cycle (default latency).
  task automatic to_wb(input logic [1:0] t, input logic [1:0] a);
    ld_type = t; addr_lo = a; start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
  endtask

  logic [8:0] zero_v;
  int w1, w15;

  initial begin
    zero_v = '0;
    reset = 1'b1; start = 1'b0; start1 = 1'b0; start15 = 1'b0; flush = 1'b0;
    ld_type = 2'd0; addr_lo = 2'd0;
    #3;
    chk("reset_async_outs", 16'(ov), 16'(zero_v));
    chk("reset_async_bh", 16'(bv), 16'h0);
    tick(2);
    chk("reset_held_outs", 16'(ov), 16'(zero_v));
    reset = 1'b0;
    tick();
    chk("post_reset_outs", 16'(ov), 16'(zero_v));
    chk("post_reset_bh", 16'(bv), 16'h0);

    // LW @0: two read cycles, latch, write-back through MDR
    ld_type = 2'd0; addr_lo = 2'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("lw_wait1", 16'(ov), 16'(ev(1, 0, 0, 0, 0, 1, 3'd0)));
    tick();
    chk("lw_wait2", 16'(ov), 16'(ev(1, 0, 0, 0, 0, 1, 3'd0)));
    tick();
    chk("lw_latch", 16'(ov), 16'(ev(0, 1, 0, 0, 0, 1, 3'd0)));
    tick();
    chk("lw_wb", 16'(ov), 16'(ev(0, 0, 1, 1, 0, 1, 3'd5)));
    chk("lw_bh", 16'(bv), 16'h0);
    tick();
    chk("lw_idle", 16'(ov), 16'(zero_v));

    to_wb(2'd2, 2'd3);
    chk("lb_wb", 16'(ov), 16'(ev(0, 0, 1, 1, 0, 1, 3'd7)));
    chk("lb_bh", 16'(bv), 16'b1110);
    tick();
    to_wb(2'd3, 2'd1);
    chk("lbu_wb", 16'(ov), 16'(ev(0, 0, 1, 1, 0, 1, 3'd7)));
    chk("lbu_bh", 16'(bv), 16'b0100);
    tick();
    to_wb(2'd1, 2'd2);
    chk("lh_wb", 16'(ov), 16'(ev(0, 0, 1, 1, 0, 1, 3'd7)));
    chk("lh_bh", 16'(bv), 16'b1011);
    tick();

    // misaligned LW then LH: one-cycle error, no read, bh regs untouched
    ld_type = 2'd0; addr_lo = 2'd2; start = 1'b1;
    tick(); start = 1'b0;
    chk("lw_mis_err", 16'(ov), 16'(ev(0, 0, 0, 0, 1, 1, 3'd0)));
    tick();
    chk("lw_mis_idle", 16'(ov), 16'(zero_v));
    ld_type = 2'd1; addr_lo = 2'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("lh_mis_err", 16'(ov), 16'(ev(0, 0, 0, 0, 1, 1, 3'd0)));
    tick();
    chk("lh_mis_idle", 16'(ov), 16'(zero_v));
    chk("mis_bh_stable", 16'(bv), 16'b1011);

    // flush during WAIT aborts with no latch or write
    ld_type = 2'd0; addr_lo = 2'd0; start = 1'b1;
    tick(); start = 1'b0;
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush_wait_idle", 16'(ov), 16'(zero_v));
    tick();
    chk("flush_wait_quiet1", 16'(ov), 16'(zero_v));
    tick();
    chk("flush_wait_quiet2", 16'(ov), 16'(zero_v));

    // flush in WB kills the write but done still pulses
    to_wb(2'd0, 2'd0);
    flush = 1'b1;
    #1;
    chk("flush_wb", 16'(ov), 16'(ev(0, 0, 0, 1, 0, 1, 3'd5)));
    tick(); flush = 1'b0;
    chk("flush_wb_idle", 16'(ov), 16'(zero_v));

    // flush beats a start in IDLE
    flush = 1'b1; start = 1'b1;
    tick(); flush = 1'b0; start = 1'b0;
    chk("flush_idle_start", 16'(ov), 16'(zero_v));

    // start held high: one load per IDLE acceptance
    ld_type = 2'd0; addr_lo = 2'd0; start = 1'b1;
    tick();
    chk("held_wait1", 16'(ov), 16'(ev(1, 0, 0, 0, 0, 1, 3'd0)));
    tick();
    chk("held_wait2", 16'(ov), 16'(ev(1, 0, 0, 0, 0, 1, 3'd0)));
    tick(2);
    chk("held_wb", 16'(ov), 16'(ev(0, 0, 1, 1, 0, 1, 3'd5)));
    tick();
    chk("held_idle", 16'(ov), 16'(zero_v));
    tick(); start = 1'b0;
    chk("held_reaccept", 16'(ov), 16'(ev(1, 0, 0, 0, 0, 1, 3'd0)));
    tick(4);
    chk("held_done_idle", 16'(ov), 16'(zero_v));

    // async reset in LATCH clears everything immediately and stays quiet
    ld_type = 2'd2; addr_lo = 2'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(2);
    chk("rst_pre_latch", 16'(ov), 16'(ev(0, 1, 0, 0, 0, 1, 3'd0)));
    #1 reset = 1'b1;
    #1;
    chk("rst_latch_outs", 16'(ov), 16'(zero_v));
    chk("rst_latch_bh", 16'(bv), 16'h0);
    tick(); reset = 1'b0;
    tick();
    chk("rst_after1", 16'(ov), 16'(zero_v));
    tick();
    chk("rst_after2", 16'(ov), 16'(zero_v));

    // latency at the MEM_WAIT extremes
    ld_type = 2'd0; addr_lo = 2'd0; start1 = 1'b1; start15 = 1'b1;
    tick(); start1 = 1'b0; start15 = 1'b0;
    w1 = -1; w15 = -1;
    for (int k = 1; k <= 25; k++) begin
      if (rw1 && w1 < 0) begin
        w1 = k;
        chk("mw1_wb_sel", 16'(sel1), 16'd5);
      end
      if (rw15 && w15 < 0) begin
        w15 = k;
        chk("mw15_wb_sel", 16'(sel15), 16'd5);
      end
      tick();
    end
    chk("mw1_latency", 16'(w1), 16'd3);
    chk("mw15_latency", 16'(w15), 16'd17);
    chk("mw_idle_after", 16'({bz1, bz15}), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_wb_ctrl.md
LOAD_WB_CTRL -- requirements
Module: load_wb_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, meaning memory read latency in cycles; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, load request; sampled only in IDLE.
REQ-005 SHALL have port ld_type, input, 2, load type: 0 LW, 1 LH, 2 LB, 3 LBU.
REQ-006 SHALL have port addr_lo, input, 2, effective address bits [1:0]; sampled with start.
REQ-007 SHALL have port flush, input, 1, abort the current load.
REQ-008 SHALL have port mem_rd, output, 1, memory read enable.
REQ-009 SHALL have port mdr_load, output, 1, memory data register write enable.
REQ-010 SHALL have port mem_to_reg, output, 3, write-back mux select.
REQ-011 SHALL have port reg_write, output, 1, register file write enable.
REQ-012 SHALL have port bh_sel, output, 2, registered addr_lo for the byte/halfword extract unit.
REQ-013 SHALL have port bh_signed, output, 1, 1 for LH/LB and 0 for LW/LBU; registered.
REQ-014 SHALL have port bh_half, output, 1, 1 for LH; registered.
REQ-015 SHALL have ports busy, done and align_err, each output, 1 bit.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, WAIT, LATCH, WB and ERR.
REQ-017 IDLE with start=1 and an aligned address SHALL capture ld_type and addr_lo, load the wait counter with MEM_WAIT-1, and go to WAIT.
REQ-018 Misalignment SHALL be defined as: LW with addr_lo!=0, or LH with addr_lo[0]=1.
REQ-019 IDLE with start=1 and a misaligned address SHALL go to ERR without asserting mem_rd.
REQ-020 WAIT SHALL hold mem_rd=1 and decrement the counter each cycle; WAIT with counter=0 SHALL go to LATCH.
REQ-021 LATCH SHALL assert mdr_load=1 for exactly one cycle, then go to WB.
REQ-022 WB SHALL assert reg_write=1 and done=1 for one cycle, then go to IDLE.
REQ-023 In WB, mem_to_reg SHALL be 5 (MDR) for LW and 7 (byte/halfword) for LH, LB and LBU.
REQ-024 Outside WB, mem_to_reg SHALL be 0.
REQ-025 ERR SHALL assert align_err=1 for one cycle, with no reg_write, then go to IDLE.
REQ-026 Latency SHALL be fixed: start accepted at edge N gives WB during cycle N+MEM_WAIT+2 (cycle N+4 at the default).
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start while busy=1 SHALL be ignored and not queued.
REQ-029 flush=1 in any non-IDLE state SHALL force IDLE on the next edge.
REQ-030 reg_write SHALL equal (state==WB) and not flush, so flush coinciding with WB suppresses the write; done SHALL still pulse.
REQ-031 flush in IDLE coinciding with start SHALL take priority: the start is dropped.
REQ-032 bh_sel, bh_signed and bh_half SHALL stay stable from acceptance until the next accepted start.

Reset
REQ-033 reset SHALL force IDLE and a counter of 0, independent of clk.
REQ-034 During and after reset, until the next accepted start: mem_rd, mdr_load, reg_write, done, align_err and busy = 0; mem_to_reg = 3'd0; bh_sel = 2'd0; bh_signed = 0; bh_half = 0.
REQ-035 reset asserted mid-load SHALL produce no reg_write or mdr_load pulse after release.

Structure
REQ-036 The shared package SHALL hold the ld_type codes, the state encoding, the mux select constants (SEL_MDR=3'd5, SEL_BH=3'd7) and the MEM_WAIT bounds.
REQ-037 The wait counter SHALL be one sub-module, ld_wait_cnt, with ports load, value and zero; the FSM stays in load_wb_ctrl.

Verification
REQ-038 Default MEM_WAIT, LW with addr_lo=0: mem_rd high 2 cycles, mdr_load at +3, reg_write with mem_to_reg=5 and done at +4.
REQ-039 LB with addr_lo=3: mem_to_reg=7, bh_sel=3, bh_signed=1, bh_half=0 in WB; LBU gives bh_signed=0.
REQ-040 LW with addr_lo=2, then LH with addr_lo=1: align_err pulse, no mem_rd, busy for 1 cycle each.
REQ-041 flush in WAIT: IDLE next cycle, no mdr_load, no reg_write. flush in WB: reg_write=0, done=1.
REQ-042 start held high through a load: exactly one load per IDLE acceptance; a start in WAIT is ignored.
REQ-043 MEM_WAIT=1, then 15: WB occurs at +3 and +17; reset asserted in LATCH gives all outputs 0 immediately.
